// File: rtl/replay_queue.sv
// replay_queue: in-order circular replay buffer that holds each entry for at least MIN_DELAY cycles
module replay_queue #(
  parameter int ENTRY_NUM  = 20,
  parameter int DATA_WIDTH = 64,
  parameter int MIN_DELAY  = 3
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             flush,
  input  logic                             enqValid,
  output logic                             enqReady,
  input  logic [DATA_WIDTH-1:0]            enqData,
  output logic                             deqValid,
  input  logic                             deqReady,
  output logic [DATA_WIDTH-1:0]            deqData,
  output logic [$clog2(ENTRY_NUM+1)-1:0]   count,
  output logic                             full,
  output logic                             empty
);
  localparam int AW = $clog2(ENTRY_NUM);
  localparam int CW = $clog2(ENTRY_NUM + 1);
  localparam int GW = MIN_DELAY > 0 ? $clog2(MIN_DELAY + 1) : 1;
  localparam logic [GW-1:0] AGE_MAX = GW'(MIN_DELAY);
  localparam logic [AW-1:0] LAST = AW'(ENTRY_NUM - 1);

  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [ENTRY_NUM];
  logic [GW-1:0]         age_q  [ENTRY_NUM];
  logic [GW-1:0]         age_d  [ENTRY_NUM];
  logic                  enq_fire, deq_fire;

  assign full     = count_q == CW'(ENTRY_NUM);
  assign empty    = count_q == '0;
  assign count    = count_q;
  assign enqReady = !full && !flush;
  // ages saturate at MIN_DELAY, so equality is the same test as >=
  assign deqValid = !empty && age_q[head_q] == AGE_MAX && !flush;
  assign deqData  = data_q[head_q];
  assign enq_fire = enqValid && enqReady;
  assign deq_fire = deqValid && deqReady;

  always_comb begin
    head_d  = flush ? '0 : deq_fire ? (head_q == LAST ? '0 : head_q + 1'b1) : head_q;
    tail_d  = flush ? '0 : enq_fire ? (tail_q == LAST ? '0 : tail_q + 1'b1) : tail_q;
    count_d = flush ? '0 : count_q + CW'(enq_fire) - CW'(deq_fire);
    for (int i = 0; i < ENTRY_NUM; i++)
      age_d[i] = (enq_fire && tail_q == AW'(i)) ? '0 :
                 age_q[i] == AGE_MAX ? age_q[i] : age_q[i] + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    age_q <= age_d;
    if (enq_fire) data_q[tail_q] <= enqData;
  end
endmodule

// File: tb/tb_replay_queue.sv
// tb_replay_queue: table vectors, corner-case sequences and a randomized queue model for replay_queue
module tb_replay_queue;
  localparam int N  = 20;
  localparam int MD = 3;

  logic        clk = 0, rstN = 0, flush = 0, enqValid = 0, deqReady = 0;
  logic [63:0] enqData = '0;
  logic        enqReady, deqValid, full, empty;
  logic [63:0] deqData;
  logic [4:0]  count;

  replay_queue #(.ENTRY_NUM(N), .DATA_WIDTH(64), .MIN_DELAY(MD)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .enqValid(enqValid), .enqReady(enqReady),
    .enqData(enqData), .deqValid(deqValid), .deqReady(deqReady), .deqData(deqData),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; int t; } ent_t;
  ent_t mq[$];
  int   cyc_n = 0;
  int   n_chk = 0, n_pass = 0;
  logic [63:0] got[$];

  typedef struct {
    logic fl, ev; logic [63:0] ed; logic dr;
    logic er, dv; logic [63:0] dd; int cnt; logic em;
  } vec_t;
  vec_t vec[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  task automatic drive(input logic fl, input logic ev, input logic [63:0] ed, input logic dr);
    @(negedge clk);
    flush = fl; enqValid = ev; enqData = ed; deqReady = dr;
    #1;
  endtask

  function automatic logic exp_dv();
    return !flush && mq.size() > 0 && cyc_n >= mq[0].t + 1 + MD;
  endfunction

  task automatic model_check();
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == N));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("enqReady", 64'(enqReady), 64'(mq.size() < N && !flush));
    chk("deqValid", 64'(deqValid), 64'(exp_dv()));
    if (exp_dv()) chk("deqData", deqData, mq[0].d);
  endtask

  task automatic model_step();
    logic e, d;
    e = enqValid && !flush && mq.size() < N;
    d = exp_dv() && deqReady;
    if (flush) mq.delete();
    else begin
      if (d) begin got.push_back(mq[0].d); void'(mq.pop_front()); end
      if (e) mq.push_back('{enqData, cyc_n});
    end
    cyc_n++;
  endtask

  task automatic cyc(input logic fl, input logic ev, input logic [63:0] ed, input logic dr);
    drive(fl, ev, ed, dr);
    model_check();
    model_step();
  endtask

  task automatic drain();
    int k = 0;
    while (mq.size() > 0 && k < 100) begin cyc(0, 0, 0, 1); k++; end
    chk("drain_done", 64'(mq.size()), 0);
  endtask

  initial begin
    vec[0] = '{0, 1, 64'hA5, 1, 1, 0, 64'h0, 0, 1};
    vec[1] = '{0, 0, 64'h0,  1, 1, 0, 64'h0, 1, 0};
    vec[2] = '{0, 0, 64'h0,  1, 1, 0, 64'h0, 1, 0};
    vec[3] = '{0, 0, 64'h0,  1, 1, 0, 64'h0, 1, 0};
    vec[4] = '{0, 0, 64'h0,  1, 1, 1, 64'hA5, 1, 0};
    vec[5] = '{0, 0, 64'h0,  1, 1, 0, 64'h0, 0, 1};
    vec[6] = '{1, 1, 64'h77, 1, 0, 0, 64'h0, 0, 1};
    vec[7] = '{0, 0, 64'h0,  0, 1, 0, 64'h0, 0, 1};

    #2;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_enqReady", 64'(enqReady), 1);
    chk("rst_deqValid", 64'(deqValid), 0);
    @(negedge clk); rstN = 1;

    // latency vectors
    for (int i = 0; i < 8; i++) begin
      drive(vec[i].fl, vec[i].ev, vec[i].ed, vec[i].dr);
      chk($sformatf("vec%0d_enqReady", i), 64'(enqReady), 64'(vec[i].er));
      chk($sformatf("vec%0d_deqValid", i), 64'(deqValid), 64'(vec[i].dv));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vec[i].cnt));
      chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vec[i].em));
      if (vec[i].dv) chk($sformatf("vec%0d_deqData", i), deqData, vec[i].dd);
      model_step();
    end

    // fill to full
    for (int i = 0; i < N; i++) cyc(0, 1, 64'(100 + i), 0);
    drive(0, 1, 64'hDEAD, 0);
    chk("full_count", 64'(count), N);
    chk("full_flag", 64'(full), 1);
    chk("full_enqReady", 64'(enqReady), 0);
    model_step();
    drive(0, 1, 64'hBEEF, 1);
    chk("full_deqValid", 64'(deqValid), 1);
    chk("full_enqReady2", 64'(enqReady), 0);
    chk("full_head", deqData, 100);
    model_step();
    drive(0, 0, 0, 0);
    chk("full_deq_count", 64'(count), N - 1);
    model_step();
    drain();

    // wrap-around streaming
    got.delete();
    for (int i = 0; i < 45; i++) cyc(0, 1, 64'(i), 1);
    drain();
    chk("wrap_n", 64'(got.size()), 45);
    for (int i = 0; i < 45 && i < got.size(); i++) chk("wrap_order", got[i], 64'(i));

    // simultaneous enq/deq at count 7
    for (int i = 0; i < 7; i++) cyc(0, 1, 64'(200 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    drive(0, 1, 64'(207), 1);
    chk("sim_count_pre", 64'(count), 7);
    chk("sim_deqValid", 64'(deqValid), 1);
    chk("sim_enqReady", 64'(enqReady), 1);
    model_step();
    drive(0, 0, 0, 0);
    chk("sim_count_post", 64'(count), 7);
    model_step();
    got.delete();
    drain();
    for (int i = 0; i < 7 && i < got.size(); i++) chk("sim_order", got[i], 64'(201 + i));

    // flush at count 12
    for (int i = 0; i < 12; i++) cyc(0, 1, 64'(300 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    drive(1, 1, 64'h55, 1);
    chk("flush_count_pre", 64'(count), 12);
    chk("flush_enqReady", 64'(enqReady), 0);
    chk("flush_deqValid", 64'(deqValid), 0);
    model_step();
    drive(0, 0, 0, 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_empty", 64'(empty), 1);
    chk("flush_deqValid_post", 64'(deqValid), 0);
    model_step();

    // asynchronous reset between edges
    for (int i = 0; i < 5; i++) cyc(0, 1, 64'(400 + i), 0);
    drive(0, 0, 0, 0);
    chk("arst_count_pre", 64'(count), 5);
    rstN = 0;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_empty", 64'(empty), 1);
    chk("arst_deqValid", 64'(deqValid), 0);
    mq.delete();
    #1 rstN = 1;
    cyc_n++;

    // randomized against the queue model
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(39) == 0, $urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(9) < 6);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/replay_queue.md
REPLAY_QUEUE -- requirements
Module: replay_queue

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 20, the number of queue entries; any value 2..64 is legal and need not be a power of two.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, the width of the opaque replay payload.
REQ-003 The block SHALL have parameter MIN_DELAY, default 3, the minimum residency in cycles before an entry may leave; legal range 0..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rstN  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline flush; discards all entries.
REQ-007 enqValid  input  1  producer offers an entry.
REQ-008 enqReady  output  1  queue accepts an entry this cycle.
REQ-009 enqData  input  DATA_WIDTH  payload to enqueue.
REQ-010 deqValid  output  1  head entry is eligible to leave.
REQ-011 deqReady  input  1  consumer takes the head entry.
REQ-012 deqData  output  DATA_WIDTH  head entry payload.
REQ-013 count  output  $clog2(ENTRY_NUM+1)  number of occupied entries.
REQ-014 full / empty  output  1 each  count==ENTRY_NUM / count==0.

Function
REQ-015 The queue SHALL be a circular buffer with head and tail pointers that each wrap from ENTRY_NUM-1 to 0; there SHALL be no power-of-two masking.
REQ-016 The enqueue handshake SHALL fire when enqValid&&enqReady.
REQ-017 enqReady SHALL be !full && !flush; a same-cycle dequeue SHALL NOT free a slot for enqueue when full.
REQ-018 On an enqueue fire, the block SHALL write enqData and age=0 at tail, then tail+1 (wrapped).
REQ-019 Each valid entry SHALL hold an age counter of width $clog2(MIN_DELAY+1) (minimum 1 bit) that increments by 1 every cycle and saturates at MIN_DELAY.
REQ-020 deqValid SHALL be !empty && age[head]>=MIN_DELAY && !flush; for an entry written at the edge ending cycle T, deqValid is first asserted in cycle T+1+MIN_DELAY.
REQ-021 The block SHALL have no enqueue-to-dequeue bypass; an entry is never visible in the cycle it is offered, even with MIN_DELAY=0.
REQ-022 deqData SHALL be driven combinationally from the head entry register and is undefined when deqValid=0.
REQ-023 On a dequeue fire (deqValid&&deqReady), head SHALL advance by 1 (wrapped); deqReady while deqValid=0 has no effect.
REQ-024 count SHALL update as count +1 on enqueue-only, -1 on dequeue-only, and unchanged on both or neither; it never exceeds ENTRY_NUM and never underflows.
REQ-025 Simultaneous enqueue and dequeue when not full and not empty SHALL both take effect in the same edge.
REQ-026 flush=1 SHALL take priority over everything else: in the flush cycle no handshake fires, and at the edge head=tail=count=0.
REQ-027 Data and age of discarded entries need not be cleared on flush.
REQ-028 The queue SHALL operate in order: dequeue order equals enqueue order.

Reset
REQ-029 On rstN=0, asynchronously, the block SHALL force head=0, tail=0, count=0, full=0, empty=1, enqReady=1, deqValid=0.
REQ-030 Entry data and age SHALL NOT require reset.
REQ-031 The release of rstN SHALL be synchronized externally; the block SHALL operate from the first rising edge after release.
REQ-032 Reset asserted mid-operation SHALL discard all entries identically to REQ-029.

Verification
REQ-033 Latency: enqueue 0xA5 at cycle 0 with deqReady=1 held -> deqValid=0 in cycles 1-3, deqValid=1 with deqData=0xA5 in cycle 4, empty=1 in cycle 5.
REQ-034 Fill/full: 20 back-to-back enqueues with deqReady=0 -> count=20, full=1, enqReady=0; a 21st enqValid is not accepted; a same-cycle dequeue plus enqValid gives count=19 with no enqueue.
REQ-035 Wrap-around: push and pop 45 sequential values (0..44) at steady state -> every value is dequeued exactly once in order; the pointers pass index 19->0 at least twice.
REQ-036 Simultaneous enqueue and dequeue at count=7 -> count stays 7 and the FIFO order is preserved.
REQ-037 Flush with count=12 plus concurrent enqValid/deqReady -> no handshake fires; next cycle count=0, empty=1, deqValid=0.
REQ-038 Asynchronous reset: assert rstN=0 between edges with count=5 -> count=0 and empty=1 immediately, before the next edge.
